// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyph codes (dp excluded),
// dp bit position and decoder FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG7_0 = 7'h40;
    localparam logic [6:0] SEG7_1 = 7'h79;
    localparam logic [6:0] SEG7_2 = 7'h24;
    localparam logic [6:0] SEG7_3 = 7'h30;
    localparam logic [6:0] SEG7_4 = 7'h19;
    localparam logic [6:0] SEG7_5 = 7'h12;
    localparam logic [6:0] SEG7_6 = 7'h02;
    localparam logic [6:0] SEG7_7 = 7'h78;
    localparam logic [6:0] SEG7_8 = 7'h00;
    localparam logic [6:0] SEG7_9 = 7'h10;
    localparam logic [6:0] SEG7_A = 7'h08;
    localparam logic [6:0] SEG7_B = 7'h03;
    localparam logic [6:0] SEG7_C = 7'h46;
    localparam logic [6:0] SEG7_D = 7'h21;
    localparam logic [6:0] SEG7_E = 7'h06;
    localparam logic [6:0] SEG7_F = 7'h0E;

    localparam int SEG7_DP_BIT = 7;
    localparam int SEG7_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HELD  = 2'd2
    } seg7_state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational active-low seven-segment to hex decoder; ok=0 for any
// pattern that is not one of the sixteen glyphs (nibble then reads 0).
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       ok
);

    always_comb begin
        nibble = 4'h0;
        ok     = 1'b1;
        case (seg)
            SEG7_0:  nibble = 4'h0;
            SEG7_1:  nibble = 4'h1;
            SEG7_2:  nibble = 4'h2;
            SEG7_3:  nibble = 4'h3;
            SEG7_4:  nibble = 4'h4;
            SEG7_5:  nibble = 4'h5;
            SEG7_6:  nibble = 4'h6;
            SEG7_7:  nibble = 4'h7;
            SEG7_8:  nibble = 4'h8;
            SEG7_9:  nibble = 4'h9;
            SEG7_A:  nibble = 4'hA;
            SEG7_B:  nibble = 4'hB;
            SEG7_C:  nibble = 4'hC;
            SEG7_D:  nibble = 4'hD;
            SEG7_E:  nibble = 4'hE;
            SEG7_F:  nibble = 4'hF;
            default: ok     = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed active-low display bus, captures each digit once it has
// been stable for STABLE_CYCLES and emits whole frames. SEG7_SYNC_EN adds a 2-flop synchroniser.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            seg_n,
    input  logic [DIGITS-1:0]     dig_en_n,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     dp_out,
    output logic                  valid,
    output logic                  err
);

    localparam logic [SEG7_CNT_W-1:0] STABLE = SEG7_CNT_W'(STABLE_CYCLES);

    logic [7:0]        seg_in;
    logic [DIGITS-1:0] en_in;

`ifdef SEG7_SYNC_EN
    logic [7:0]        seg_m_q, seg_s_q;
    logic [DIGITS-1:0] en_m_q, en_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_m_q <= '1;
            seg_s_q <= '1;
            en_m_q  <= '1;
            en_s_q  <= '1;
        end else begin
            seg_m_q <= seg_n;
            seg_s_q <= seg_m_q;
            en_m_q  <= dig_en_n;
            en_s_q  <= en_m_q;
        end
    end

    assign seg_in = seg_s_q;
    assign en_in  = en_s_q;
`else
    assign seg_in = seg_n;
    assign en_in  = dig_en_n;
`endif

    logic [7:0]                  s_seg_q;
    logic [DIGITS-1:0]           s_en_q;
    seg7_state_e                 state_q, state_d;
    logic [SEG7_CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]                  prev_idx_q;
    logic [7:0]                  prev_seg_q;
    logic [DIGITS-1:0][3:0]      shadow_q, shadow_d;
    logic [DIGITS-1:0]           sdp_q, sdp_d;
    logic [DIGITS-1:0]           seen_q, seen_d;
    logic                        frame_err_q, frame_err_d;
    logic [DIGITS-1:0][3:0]      value_q, value_d;
    logic [DIGITS-1:0]           dp_q, dp_d;
    logic                        valid_q, valid_d;
    logic                        err_q, err_d;

    logic [3:0] n_low;
    logic [2:0] act_idx;
    logic       active, conflict, same, capture;
    logic [3:0] dec_nib;
    logic       dec_ok;

    // Blanking and multi-enable conflicts both read as "no active digit".
    always_comb begin
        n_low   = 4'd0;
        act_idx = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!s_en_q[i]) begin
                n_low   = n_low + 4'd1;
                act_idx = 3'(i);
            end
        end
    end

    assign active   = (n_low == 4'd1);
    assign conflict = (n_low > 4'd1);
    assign same     = (act_idx == prev_idx_q) && (s_seg_q == prev_seg_q);

    seg7_to_hex u_dec (
        .seg    (s_seg_q[6:0]),
        .nibble (dec_nib),
        .ok     (dec_ok)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (active) begin
                    state_d = TRACK;
                    cnt_d   = SEG7_CNT_W'(1);
                end
            end
            TRACK, HELD: begin
                if (!active) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    state_d = TRACK;
                    cnt_d   = SEG7_CNT_W'(1);
                end else if (state_q == TRACK && cnt_q != STABLE) begin
                    cnt_d = cnt_q + SEG7_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Also covers STABLE_CYCLES=1, where the very first sample captures.
        if (state_d == TRACK && cnt_d == STABLE) begin
            capture = 1'b1;
            state_d = HELD;
        end
    end

    always_comb begin
        shadow_d    = shadow_q;
        sdp_d       = sdp_q;
        seen_d      = seen_q;
        frame_err_d = frame_err_q;
        value_d     = value_q;
        dp_d        = dp_q;
        err_d       = err_q;
        valid_d     = 1'b0;
        if (&seen_q) begin
            value_d     = shadow_q;
            dp_d        = sdp_q;
            err_d       = frame_err_q;
            valid_d     = 1'b1;
            seen_d      = '0;
            frame_err_d = 1'b0;
        end
        // Applied after the completion clear so coincident events join the new frame.
        if (conflict) begin
            frame_err_d = 1'b1;
        end
        if (capture) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (act_idx == 3'(i)) begin
                    shadow_d[i] = dec_nib;
                    sdp_d[i]    = ~s_seg_q[SEG7_DP_BIT];
                    seen_d[i]   = 1'b1;
                end
            end
            if (!dec_ok) begin
                frame_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_seg_q     <= '1;
            s_en_q      <= '1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            prev_idx_q  <= '0;
            prev_seg_q  <= '1;
            shadow_q    <= '0;
            sdp_q       <= '0;
            seen_q      <= '0;
            frame_err_q <= 1'b0;
            value_q     <= '0;
            dp_q        <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            s_seg_q     <= seg_in;
            s_en_q      <= en_in;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_idx_q  <= act_idx;
            prev_seg_q  <= s_seg_q;
            shadow_q    <= shadow_d;
            sdp_q       <= sdp_d;
            seen_q      <= seen_d;
            frame_err_q <= frame_err_d;
            value_q     <= value_d;
            dp_q        <= dp_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign value  = value_q;
    assign dp_out = dp_q;
    assign valid  = valid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench: a window-level model of the display bus predicts each
// frame (content and arrival cycle); a monitor checks every valid and output hold.
module tb_seg7_scan_decoder;

    localparam int DIGITS = 4;
    localparam int S      = 4;
`ifdef SEG7_SYNC_EN
    localparam int LAT_X = 2;
`else
    localparam int LAT_X = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  seg_n = 8'hFF;
    logic [3:0]  dig_en_n = 4'hF;
    logic [15:0] value;
    logic [3:0]  dp_out;
    logic        valid, err;

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .seg_n    (seg_n),
        .dig_en_n (dig_en_n),
        .value    (value),
        .dp_out   (dp_out),
        .valid    (valid),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dp;
        logic        err;
        int          at;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: tracks runs of identical (enable, segment) windows.
    logic [15:0] m_val;
    logic [3:0]  m_dp, m_seen;
    logic        m_err;
    logic [3:0]  last_en;
    logic [7:0]  last_seg;
    int          run_start, run_len;
    bit          captured;

    task automatic model_clear();
        m_val = '0; m_dp = '0; m_seen = '0; m_err = 1'b0;
        last_en = 4'hF; last_seg = 8'hFF; run_start = 0; run_len = 0; captured = 0;
    endtask

    task automatic model_win(input logic [3:0] en, input logic [7:0] sg, input int len, input int c);
        int  nlow, idx;
        logic [3:0] nib;
        bit  ok;
        nlow = 0; idx = 0;
        for (int i = 0; i < DIGITS; i++)
            if (!en[i]) begin nlow++; idx = i; end
        if (nlow != 1) begin
            if (nlow > 1) m_err = 1'b1;
            last_en = 4'hF;
            captured = 0;
            return;
        end
        if (en == last_en && sg == last_seg) run_len += len;
        else begin
            last_en = en; last_seg = sg; run_start = c; run_len = len; captured = 0;
        end
        if (!captured && run_len >= S) begin
            captured = 1;
            nib = 4'h0; ok = 0;
            for (int k = 0; k < 16; k++)
                if (codes[k] == sg[6:0]) begin nib = 4'(k); ok = 1; end
            if (!ok) m_err = 1'b1;
            m_val[idx*4 +: 4] = nib;
            m_dp[idx]   = ~sg[7];
            m_seen[idx] = 1'b1;
            if (m_seen == 4'hF) begin
                q.push_back('{val: m_val, dp: m_dp, err: m_err, at: run_start + S + 2 + LAT_X});
                m_seen = '0;
                m_err  = 1'b0;
            end
        end
    endtask

    logic [15:0] last_val = '0;
    logic [3:0]  last_dp  = '0;
    logic        last_err = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (valid) begin
                if (q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
                else begin
                    mon_e = q.pop_front();
                    chk("frame_value", 32'(value), 32'(mon_e.val));
                    chk("frame_dp", 32'(dp_out), 32'(mon_e.dp));
                    chk("frame_err", 32'(err), 32'(mon_e.err));
                    chk("frame_cycle", 32'(cyc), 32'(mon_e.at));
                    last_val = mon_e.val; last_dp = mon_e.dp; last_err = mon_e.err;
                end
            end else begin
                chk("hold_outputs", {11'd0, value, dp_out, err}, {11'd0, last_val, last_dp, last_err});
            end
        end
    end

    task automatic win(input logic [3:0] en, input logic [7:0] sg, input int len);
        model_win(en, sg, len, cyc);
        dig_en_n = en;
        seg_n    = sg;
        repeat (len) @(negedge clk);
    endtask

    task automatic frame4(input logic [7:0] s0, input logic [7:0] s1,
                          input logic [7:0] s2, input logic [7:0] s3);
        win(4'b1110, s0, 8);
        win(4'b1101, s1, 8);
        win(4'b1011, s2, 8);
        win(4'b0111, s3, 8);
        win(4'b1111, 8'hFF, 6);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        last_val = '0; last_dp = '0; last_err = 1'b0;
        model_clear();
        repeat (n) begin
            seg_n    = 8'($urandom);
            dig_en_n = 4'($urandom);
            @(negedge clk);
        end
        rst = 1'b0;
        seg_n = 8'hFF;
        dig_en_n = 4'hF;
    endtask

    initial begin
        int          r, d, len, start, nwin;
        logic [3:0]  en;
        logic [7:0]  sg;
        model_clear();
        @(negedge clk);
        do_reset(3);
        chk("reset_value", 32'(value), 32'd0);
        chk("reset_dp", 32'(dp_out), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        win(4'hF, 8'hFF, 20);

        frame4(8'hF9, 8'hA4, 8'hB0, 8'h99);
        chk("scan_value", 32'(value), 32'h4321);
        chk("scan_dp_err", {27'd0, dp_out, err}, 32'd0);

        win(4'b1110, 8'hC0, 2);
        frame4(8'hF9, 8'h92, 8'h82, 8'hF8);
        chk("glitch_value", 32'(value), 32'h7651);

        frame4(8'h99, 8'hB0, 8'hFF, 8'hA4);
        chk("invalid_value", 32'(value), 32'h2034);
        chk("invalid_err", 32'(err), 32'd1);
        frame4(8'hF9, 8'hA4, 8'hB0, 8'h99);
        chk("clean_err", 32'(err), 32'd0);

        win(4'b1110, 8'hF9, 8);
        win(4'b1101, 8'h40, 8);
        win(4'b1100, 8'hF9, 8);
        win(4'b1011, 8'hA4, 8);
        win(4'b0111, 8'hB0, 8);
        win(4'hF, 8'hFF, 6);
        chk("dp_value", 32'(value), 32'h3201);
        chk("dp_out", 32'(dp_out), 32'h2);
        chk("conflict_err", 32'(err), 32'd1);

        win(4'b1110, 8'h80, 8);
        win(4'b1101, 8'h90, 8);
        win(4'b1011, 8'h88, 8);
        do_reset(2);
        chk("midreset_value", 32'(value), 32'd0);
        frame4(8'hF9, 8'hA4, 8'hB0, 8'h99);
        chk("post_reset_value", 32'(value), 32'h4321);

        for (int f = 0; f < 40; f++) begin
            start = $urandom_range(0, 3);
            nwin  = 4 + $urandom_range(0, 2);
            for (int k = 0; k < nwin; k++) begin
                d   = (start + k) % 4;
                r   = $urandom_range(0, 99);
                len = $urandom_range(2, 9);
                if (r < 8) en = 4'hF;
                else if (r < 16) en = ~(4'b0011 << $urandom_range(0, 2));
                else en = ~(4'b0001 << d);
                r = $urandom_range(0, 99);
                if (r < 10) sg = {1'($urandom), 7'($urandom)};
                else sg = {1'($urandom), codes[$urandom_range(0, 15)]};
                win(en, sg, len);
            end
            if ($urandom_range(0, 3) == 0) win(4'hF, 8'hFF, $urandom_range(1, 4));
        end

        win(4'hF, 8'hFF, 10);
        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        chk("drain_queue", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
